// File: rtl/seq_stim_ctrl.sv
// seq_stim_ctrl
//
// Sequencer that drives a serial stimulus pattern into a Mealy and a Moore
// sequence detector and counts how often each one reports a match.
//
// For every pattern bit (MSB-first, from bit len-1 down to bit 0) the
// controller holds x_out stable for HOLD_CYCLES cycles (SETUP), pulses det_en
// for one cycle (STROBE), then samples the Moore output (SAMPLE). The Mealy
// output is sampled on the last SETUP cycle, while the detector still sees the
// new input bit but before it steps. After the last bit, done pulses for one
// cycle (DONE) and the FSM returns to IDLE.
//
// Optional feature (compile-time macro SEQ_DET_RESET_EN):
//   defined   : a one-cycle CLEAR state follows every accepted start and drives
//               det_rst_n low so both detectors begin from their initial state.
//   undefined : no CLEAR state; det_rst_n simply follows rst.
//
// Parameters
//   HOLD_CYCLES  cycles x_out is held before each detector step (legal 1..15)
//
// Ports
//   clk        in   1  single clock, rising edge
//   rst        in   1  synchronous reset, active-low
//   start      in   1  request to run a sequence, sampled only in IDLE
//   abort      in   1  terminates a running sequence (no done pulse)
//   pattern    in   8  stimulus bits
//   pat_len    in   4  number of bits to apply (0 or >8 treated as 8)
//   z_mealy    in   1  Mealy detector output
//   z_moore    in   1  Moore detector output
//   x_out      out  1  serial stimulus bit to both detectors
//   det_en     out  1  one-cycle step enable for both detectors
//   det_rst_n  out  1  active-low detector reset
//   busy       out  1  high in every state except IDLE
//   done       out  1  one-cycle pulse on normal completion
//   mealy_cnt  out  4  Mealy match count of the last run
//   moore_cnt  out  4  Moore match count of the last run

module seq_stim_ctrl #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] pattern,
    input  logic [3:0] pat_len,
    input  logic       z_mealy,
    input  logic       z_moore,
    output logic       x_out,
    output logic       det_en,
    output logic       det_rst_n,
    output logic       busy,
    output logic       done,
    output logic [3:0] mealy_cnt,
    output logic [3:0] moore_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        SAMPLE = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Reload value of the hold counter: it counts down to 0, so SETUP lasts
    // exactly HOLD_CYCLES cycles.
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state_q;
    logic [7:0] pat_q;
    logic [2:0] bit_idx_q;
    logic [3:0] hold_q;
    logic       x_out_q;
    logic       det_en_q;
    logic       busy_q;
    logic       done_q;
    logic [3:0] mealy_cnt_q;
    logic [3:0] moore_cnt_q;

    logic [3:0] len_d;
    logic [2:0] first_idx_d;
    logic [2:0] next_idx_d;
    logic [3:0] mealy_inc_d;
    logic [3:0] moore_inc_d;

    // Length 0 and anything above 8 both mean "the whole byte".
    function automatic logic [3:0] clamp_len(input logic [3:0] l);
        if (l == 4'd0 || l > 4'd8) begin
            return 4'd8;
        end
        return l;
    endfunction

    // Counters stop at 8; with at most 8 bits per run they never need more.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        if (v >= 4'd8) begin
            return 4'd8;
        end
        return v + 4'd1;
    endfunction

    always_comb begin
        len_d       = clamp_len(pat_len);
        first_idx_d = 3'(len_d - 4'd1);
        next_idx_d  = bit_idx_q - 3'd1;
        mealy_inc_d = sat_inc(mealy_cnt_q);
        moore_inc_d = sat_inc(moore_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_idx_q   <= 3'd0;
            hold_q      <= 4'd0;
            x_out_q     <= 1'b0;
            det_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mealy_cnt_q <= 4'd0;
            moore_cnt_q <= 4'd0;
        end else begin
            // det_en and done are single-cycle pulses unless re-asserted below.
            det_en_q <= 1'b0;
            done_q   <= 1'b0;

            // Abort wins over every transition of a running sequence, so the
            // pending det_en / done / counter update of this edge is dropped.
            if (state_q != IDLE && abort) begin
                state_q <= IDLE;
                x_out_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        // abort has no meaning here, so start wins if both are set.
                        if (start) begin
                            pat_q       <= pattern;
                            bit_idx_q   <= first_idx_d;
                            mealy_cnt_q <= 4'd0;
                            moore_cnt_q <= 4'd0;
                            busy_q      <= 1'b1;
`ifdef SEQ_DET_RESET_EN
                            state_q     <= CLEAR;
                            x_out_q     <= 1'b0;
`else
                            state_q     <= SETUP;
                            x_out_q     <= pattern[first_idx_d];
                            hold_q      <= HOLD_LAST;
`endif
                        end
                    end

                    CLEAR: begin
                        state_q <= SETUP;
                        x_out_q <= pat_q[bit_idx_q];
                        hold_q  <= HOLD_LAST;
                    end

                    SETUP: begin
                        if (hold_q == 4'd0) begin
                            if (z_mealy) begin
                                mealy_cnt_q <= mealy_inc_d;
                            end
                            state_q  <= STROBE;
                            det_en_q <= 1'b1;
                        end else begin
                            hold_q <= hold_q - 4'd1;
                        end
                    end

                    STROBE: begin
                        state_q <= SAMPLE;
                    end

                    SAMPLE: begin
                        if (z_moore) begin
                            moore_cnt_q <= moore_inc_d;
                        end
                        if (bit_idx_q != 3'd0) begin
                            bit_idx_q <= next_idx_d;
                            x_out_q   <= pat_q[next_idx_d];
                            hold_q    <= HOLD_LAST;
                            state_q   <= SETUP;
                        end else begin
                            x_out_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end

                    DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end

                    default: begin
                        x_out_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef SEQ_DET_RESET_EN
    // Detectors are held in reset during system reset and during CLEAR.
    assign det_rst_n = rst & (state_q != CLEAR);
`else
    assign det_rst_n = rst;
`endif

    assign x_out     = x_out_q;
    assign det_en    = det_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mealy_cnt = mealy_cnt_q;
    assign moore_cnt = moore_cnt_q;

endmodule

// File: tb/tb_seq_stim_ctrl.sv
module tb_seq_stim_ctrl;

    localparam int HOLD = 4;
`ifdef SEQ_DET_RESET_EN
    localparam int OFF = 1;
`else
    localparam int OFF = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic       z_mealy;
    logic       z_moore;
    logic       x_out;
    logic       det_en;
    logic       det_rst_n;
    logic       busy;
    logic       done;
    logic [3:0] mealy_cnt;
    logic [3:0] moore_cnt;

    always #5 clk = ~clk;

    seq_stim_ctrl #(.HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .pat_len   (pat_len),
        .z_mealy   (z_mealy),
        .z_moore   (z_moore),
        .x_out     (x_out),
        .det_en    (det_en),
        .det_rst_n (det_rst_n),
        .busy      (busy),
        .done      (done),
        .mealy_cnt (mealy_cnt),
        .moore_cnt (moore_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    int   det_cyc [16];
    logic det_x   [16];
    logic det_xp  [16];
    int   n_det, n_done, done_cyc, end_cyc, n_rstlow, rstlow_first;
    logic [7:0] xs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one edge; afterwards the bench sits in cycle 1.
    // The pattern input is scrambled afterwards so only the latched copy matters.
    task automatic launch(input logic [7:0] p, input logic [3:0] l);
        pattern = p;
        pat_len = l;
        start   = 1'b1;
        tick();
        pattern = ~p;
    endtask

    // Observe cycles 1..max_c of a run; optionally pulse start or abort in cycle ev_c.
    task automatic run_watch(input int max_c, input int ev_c, input logic ev_start,
                             input logic ev_abort);
        logic xp;
        n_det = 0; n_done = 0; done_cyc = -1; end_cyc = -1;
        n_rstlow = 0; rstlow_first = -1;
        xp = x_out;
        for (int c = 1; c <= max_c; c++) begin
            start = ev_start && (c == ev_c);
            abort = ev_abort && (c == ev_c);
            if (det_en) begin
                if (n_det < 16) begin
                    det_cyc[n_det] = c;
                    det_x[n_det]   = x_out;
                    det_xp[n_det]  = xp;
                end
                n_det++;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (!det_rst_n) begin
                n_rstlow++;
                if (rstlow_first < 0) rstlow_first = c;
            end
            if (!busy) begin
                end_cyc = c;
                break;
            end
            xp = x_out;
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        pattern = 8'h00; pat_len = 4'd0; z_mealy = 1'b0; z_moore = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_x_out", x_out, 1'b0);
        chk("rst_det_en", det_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_mealy_cnt", mealy_cnt, 4'd0);
        chk("rst_moore_cnt", moore_cnt, 4'd0);
        chk("rst_det_rst_n_low", det_rst_n, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_det_rst_n_high", det_rst_n, 1'b1);
        tick();
        chk("idle_busy", busy, 1'b0);

        // 4 bits 1,0,1,1 with detectors silent
        xs = 8'b0000_1011;
        launch(8'hBB, 4'd4);
        run_watch(80, 0, 1'b0, 1'b0);
        chk("t1_n_det", n_det, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_det_cyc%0d", i), det_cyc[i], 5 + 6 * i + OFF);
            chk($sformatf("t1_x%0d", i), det_x[i], xs[3 - i]);
            chk($sformatf("t1_xhold%0d", i), det_xp[i], xs[3 - i]);
        end
        chk("t1_done_cyc", done_cyc, 25 + OFF);
        chk("t1_n_done", n_done, 1);
        chk("t1_end_cyc", end_cyc, 26 + OFF);
        chk("t1_rstlow_cnt", n_rstlow, OFF);
        chk("t1_mealy", mealy_cnt, 4'd0);
        chk("t1_moore", moore_cnt, 4'd0);
        chk("t1_idle_x", x_out, 1'b0);

        // pat_len 0 -> 8 bits, both detectors always matching
        z_mealy = 1'b1; z_moore = 1'b1;
        xs = 8'b1010_0101;
        launch(8'hA5, 4'd0);
        run_watch(80, 0, 1'b0, 1'b0);
        chk("t2_n_det", n_det, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_x%0d", i), det_x[i], xs[7 - i]);
        end
        chk("t2_last_det_cyc", det_cyc[7], 47 + OFF);
        chk("t2_done_cyc", done_cyc, 49 + OFF);
        chk("t2_mealy", mealy_cnt, 4'd8);
        chk("t2_moore", moore_cnt, 4'd8);
        tick(); tick(); tick();
        chk("t2_hold_mealy", mealy_cnt, 4'd8);
        chk("t2_hold_moore", moore_cnt, 4'd8);

        // 3 bits 1,1,0; only the Mealy detector matches
        z_mealy = 1'b1; z_moore = 1'b0;
        launch(8'h06, 4'd3);
        run_watch(80, 0, 1'b0, 1'b0);
        chk("t3_n_det", n_det, 3);
        chk("t3_x0", det_x[0], 1'b1);
        chk("t3_x1", det_x[1], 1'b1);
        chk("t3_x2", det_x[2], 1'b0);
        chk("t3_done_cyc", done_cyc, 19 + OFF);
        chk("t3_mealy", mealy_cnt, 4'd3);
        chk("t3_moore", moore_cnt, 4'd0);

        // pat_len 12 is treated as 8
        z_mealy = 1'b0; z_moore = 1'b1;
        launch(8'h81, 4'd12);
        run_watch(80, 0, 1'b0, 1'b0);
        chk("t4_n_det", n_det, 8);
        chk("t4_x_first", det_x[0], 1'b1);
        chk("t4_x_mid", det_x[3], 1'b0);
        chk("t4_x_last", det_x[7], 1'b1);
        chk("t4_done_cyc", done_cyc, 49 + OFF);
        chk("t4_mealy", mealy_cnt, 4'd0);
        chk("t4_moore", moore_cnt, 4'd8);

        // start pulsed again while busy is ignored
        z_mealy = 1'b0; z_moore = 1'b0;
        launch(8'h02, 4'd2);
        run_watch(80, 5, 1'b1, 1'b0);
        chk("t5_n_det", n_det, 2);
        chk("t5_done_cyc", done_cyc, 13 + OFF);
        chk("t5_end_cyc", end_cyc, 14 + OFF);
        tick();
        chk("t5_no_restart", busy, 1'b0);

        // abort on the edge that would enter the 2nd STROBE
        z_mealy = 1'b1; z_moore = 1'b1;
        launch(8'hBB, 4'd4);
        run_watch(80, 10 + OFF, 1'b0, 1'b1);
        chk("t6_end_cyc", end_cyc, 11 + OFF);
        chk("t6_n_det", n_det, 1);
        chk("t6_n_done", n_done, 0);
        chk("t6_det_en", det_en, 1'b0);
        chk("t6_x_out", x_out, 1'b0);
        chk("t6_mealy_partial", mealy_cnt, 4'd1);
        chk("t6_moore_partial", moore_cnt, 4'd1);
        tick(); tick();
        chk("t6_stays_idle", busy, 1'b0);
        chk("t6_no_done", done, 1'b0);

        // abort on the edge that would enter DONE
        launch(8'h01, 4'd1);
        run_watch(80, 6 + OFF, 1'b0, 1'b1);
        chk("t7_end_cyc", end_cyc, 7 + OFF);
        chk("t7_n_done", n_done, 0);
        chk("t7_n_det", n_det, 1);
        chk("t7_mealy", mealy_cnt, 4'd1);
        chk("t7_moore", moore_cnt, 4'd0);

        // start and abort together in IDLE: start wins
        z_mealy = 1'b0; z_moore = 1'b0;
        pattern = 8'h01; pat_len = 4'd1;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("t8_busy", busy, 1'b1);
        run_watch(80, 0, 1'b0, 1'b0);
        chk("t8_done_cyc", done_cyc, 7 + OFF);
        chk("t8_rstlow_first", rstlow_first, (OFF == 1) ? 1 : -1);

        // reset during SETUP of the third bit, with start and abort also high
        z_mealy = 1'b1; z_moore = 1'b1;
        launch(8'hBB, 4'd4);
        run_watch(13, 0, 1'b0, 1'b0);
        chk("t9_busy_before", busy, 1'b1);
        chk("t9_x_before", x_out, 1'b1);
        rst = 1'b0; start = 1'b1; abort = 1'b1;
        tick();
        chk("t9_busy", busy, 1'b0);
        chk("t9_x_out", x_out, 1'b0);
        chk("t9_det_en", det_en, 1'b0);
        chk("t9_done", done, 1'b0);
        chk("t9_mealy", mealy_cnt, 4'd0);
        chk("t9_moore", moore_cnt, 4'd0);
        chk("t9_det_rst_n", det_rst_n, 1'b0);
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        tick();
        chk("t9_idle", busy, 1'b0);
        launch(8'h01, 4'd1);
        run_watch(80, 0, 1'b0, 1'b0);
        chk("t9_rerun_n_det", n_det, 1);
        chk("t9_rerun_x", det_x[0], 1'b1);
        chk("t9_rerun_done_cyc", done_cyc, 7 + OFF);
        chk("t9_rerun_mealy", mealy_cnt, 4'd1);
        chk("t9_rerun_moore", moore_cnt, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
